// File: rtl/main_control_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | main_control_fsm                                                         |
// | Multicycle Moore control FSM for a MIPS-style datapath.                  |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module main_control_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic       illegal_op,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [2:0] alu_op,
  output logic [3:0] state
);

  localparam logic [3:0] c_ST_IDLE   = 4'd0;
  localparam logic [3:0] c_ST_FETCH  = 4'd1;
  localparam logic [3:0] c_ST_DECODE = 4'd2;
  localparam logic [3:0] c_ST_MEMADR = 4'd3;
  localparam logic [3:0] c_ST_MEMRD  = 4'd4;
  localparam logic [3:0] c_ST_MEMWB  = 4'd5;
  localparam logic [3:0] c_ST_MEMWR  = 4'd6;
  localparam logic [3:0] c_ST_RTEX   = 4'd7;
  localparam logic [3:0] c_ST_RTWB   = 4'd8;
  localparam logic [3:0] c_ST_BRANCH = 4'd9;
  localparam logic [3:0] c_ST_IMMEX  = 4'd10;
  localparam logic [3:0] c_ST_IMMWB  = 4'd11;
  localparam logic [3:0] c_ST_JUMP   = 4'd12;

  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_J     = 6'b000010;
  localparam logic [5:0] c_OP_ADDI  = 6'b001000;
  localparam logic [5:0] c_OP_ANDI  = 6'b001100;
  localparam logic [5:0] c_OP_ORI   = 6'b001101;
  localparam logic [5:0] c_OP_SLTI  = 6'b001010;

  logic [3:0] r_state;
  logic [3:0] w_next_state;
  logic [5:0] r_op_q;
  logic [3:0] w_decode_target;
  logic       w_decode_illegal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_ST_IDLE;
      r_op_q  <= 6'b000000;
    end else begin
      r_state <= w_next_state;
      if (r_state == c_ST_DECODE) begin
        r_op_q <= opcode;
      end
    end
  end

  // Opcode classification is only consumed while in DECODE.
  always_comb begin
    w_decode_target  = c_ST_FETCH;
    w_decode_illegal = 1'b0;
    case (opcode)
      c_OP_LW, c_OP_SW:                          w_decode_target = c_ST_MEMADR;
      c_OP_RTYPE:                                w_decode_target = c_ST_RTEX;
      c_OP_BEQ:                                  w_decode_target = c_ST_BRANCH;
      c_OP_J:                                    w_decode_target = c_ST_JUMP;
      c_OP_ADDI, c_OP_ANDI, c_OP_ORI, c_OP_SLTI: w_decode_target = c_ST_IMMEX;
      default:                                   w_decode_illegal = 1'b1;
    endcase
  end

  always_comb begin
    w_next_state = c_ST_FETCH;
    case (r_state)
      c_ST_FETCH:  w_next_state = mem_ready ? c_ST_DECODE : c_ST_FETCH;
      c_ST_DECODE: w_next_state = w_decode_target;
      c_ST_MEMADR: w_next_state = (r_op_q == c_OP_LW) ? c_ST_MEMRD : c_ST_MEMWR;
      c_ST_MEMRD:  w_next_state = mem_ready ? c_ST_MEMWB : c_ST_MEMRD;
      c_ST_MEMWR:  w_next_state = mem_ready ? c_ST_FETCH : c_ST_MEMWR;
      c_ST_RTEX:   w_next_state = c_ST_RTWB;
      c_ST_IMMEX:  w_next_state = c_ST_IMMWB;
      default:     w_next_state = c_ST_FETCH;
    endcase
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    illegal_op    = 1'b0;
    alu_src_b     = 2'b00;
    pc_source     = 2'b00;
    alu_op        = 3'b000;
    state         = r_state;
    case (r_state)
      c_ST_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        alu_src_b = 2'b01;
      end
      c_ST_DECODE: begin
        alu_src_b  = 2'b11;
        illegal_op = w_decode_illegal;
      end
      c_ST_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      c_ST_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      c_ST_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      c_ST_MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      c_ST_RTEX: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b010;
      end
      c_ST_RTWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      c_ST_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 3'b001;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      c_ST_IMMEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        case (r_op_q)
          c_OP_ANDI: alu_op = 3'b011;
          c_OP_ORI:  alu_op = 3'b100;
          c_OP_SLTI: alu_op = 3'b101;
          default:   alu_op = 3'b000;
        endcase
      end
      c_ST_IMMWB: begin
        reg_write = 1'b1;
      end
      c_ST_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      default: begin
        // Codes 13-15 are treated exactly like IDLE, including the debug state.
        state = c_ST_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_main_control_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_main_control_fsm                                                      |
// | Table-driven self-checking bench for main_control_fsm.                   |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_main_control_fsm;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  main_control_fsm u_dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .illegal_op(illegal_op), .alu_src_b(alu_src_b),
    .pc_source(pc_source), .alu_op(alu_op), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pcw,pcwc,iord,mrd,mwr,irw,m2r,rdst,rw,asa,ill,asb[2],pcs[2],aop[3],state[4]}
  logic [21:0] w_got;
  assign w_got = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                  mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op,
                  alu_src_b, pc_source, alu_op, state};

  function automatic logic [21:0] mk(
    input logic [3:0] st, input logic pcw, input logic pcwc, input logic iord,
    input logic mrd, input logic mwr, input logic irw, input logic m2r,
    input logic rdst, input logic rw, input logic asa, input logic ill,
    input logic [1:0] asb, input logic [1:0] pcs, input logic [2:0] aop);
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, ill, asb, pcs, aop, st};
  endfunction

  typedef struct {
    logic [5:0]  op;
    logic        mr;
    logic [21:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [21:0] exp);
    checks++;
    if (w_got !== exp) begin
      errors++;
      $display("FAIL %s: got %06h expected %06h (state got %0d)", name, w_got, exp, state);
    end
  endtask

  task automatic add(input logic [5:0] op, input logic mr, input logic [21:0] exp,
                     input string name);
    vec_t v;
    v.op = op; v.mr = mr; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endtask

  localparam logic [21:0] c_ZERO   = 22'd0;
  localparam logic [21:0] c_FETCH  = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,5'b00000,2'b01,2'b00,3'b000,4'd1};
  localparam logic [21:0] c_FWAIT  = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,5'b00000,2'b01,2'b00,3'b000,4'd1};
  localparam logic [21:0] c_DECODE = {11'b0,2'b11,2'b00,3'b000,4'd2};

  initial begin
    logic [21:0] e_memadr, e_memrd, e_memwb, e_memwr, e_rtex, e_rtwb;
    logic [21:0] e_immwb, e_branch, e_jump, e_ill;
    e_memadr = mk(4'd3, 0,0,0,0,0,0,0,0,0,1,0, 2'b10, 2'b00, 3'b000);
    e_memrd  = mk(4'd4, 0,0,1,1,0,0,0,0,0,0,0, 2'b00, 2'b00, 3'b000);
    e_memwb  = mk(4'd5, 0,0,0,0,0,0,1,0,1,0,0, 2'b00, 2'b00, 3'b000);
    e_memwr  = mk(4'd6, 0,0,1,0,1,0,0,0,0,0,0, 2'b00, 2'b00, 3'b000);
    e_rtex   = mk(4'd7, 0,0,0,0,0,0,0,0,0,1,0, 2'b00, 2'b00, 3'b010);
    e_rtwb   = mk(4'd8, 0,0,0,0,0,0,0,1,1,0,0, 2'b00, 2'b00, 3'b000);
    e_branch = mk(4'd9, 0,1,0,0,0,0,0,0,0,1,0, 2'b00, 2'b01, 3'b001);
    e_immwb  = mk(4'd11,0,0,0,0,0,0,0,0,1,0,0, 2'b00, 2'b00, 3'b000);
    e_jump   = mk(4'd12,1,0,0,0,0,0,0,0,0,0,0, 2'b00, 2'b10, 3'b000);
    e_ill    = mk(4'd2, 0,0,0,0,0,0,0,0,0,0,1, 2'b11, 2'b00, 3'b000);

    // lw, with one FETCH stall on the following instruction
    add(6'b000000, 1, c_ZERO,   "idle");
    add(6'b000000, 1, c_FETCH,  "lw_fetch");
    add(6'b100011, 1, c_DECODE, "lw_decode");
    add(6'b000000, 1, e_memadr, "lw_memadr");
    add(6'b000000, 1, e_memrd,  "lw_memrd");
    add(6'b000000, 1, e_memwb,  "lw_memwb");
    add(6'b000000, 0, c_FWAIT,  "fetch_stall");
    // sw with three wait cycles; opcode flips in MEMADR must not matter
    add(6'b000000, 1, c_FETCH,  "sw_fetch");
    add(6'b101011, 1, c_DECODE, "sw_decode");
    add(6'b100011, 1, e_memadr, "sw_memadr");
    add(6'b100011, 0, e_memwr,  "sw_wait1");
    add(6'b000000, 0, e_memwr,  "sw_wait2");
    add(6'b000000, 0, e_memwr,  "sw_wait3");
    add(6'b000000, 1, e_memwr,  "sw_done");
    // R-type
    add(6'b000000, 1, c_FETCH,  "rt_fetch");
    add(6'b000000, 1, c_DECODE, "rt_decode");
    add(6'b100011, 1, e_rtex,   "rt_ex");
    add(6'b000000, 1, e_rtwb,   "rt_wb");
    // immediates
    add(6'b000000, 1, c_FETCH,  "addi_fetch");
    add(6'b001000, 1, c_DECODE, "addi_decode");
    add(6'b000000, 1, mk(4'd10,0,0,0,0,0,0,0,0,0,1,0,2'b10,2'b00,3'b000), "addi_ex");
    add(6'b000000, 1, e_immwb,  "addi_wb");
    add(6'b000000, 1, c_FETCH,  "andi_fetch");
    add(6'b001100, 1, c_DECODE, "andi_decode");
    add(6'b000000, 1, mk(4'd10,0,0,0,0,0,0,0,0,0,1,0,2'b10,2'b00,3'b011), "andi_ex");
    add(6'b000000, 1, e_immwb,  "andi_wb");
    add(6'b000000, 1, c_FETCH,  "ori_fetch");
    add(6'b001101, 1, c_DECODE, "ori_decode");
    add(6'b001000, 1, mk(4'd10,0,0,0,0,0,0,0,0,0,1,0,2'b10,2'b00,3'b100), "ori_ex");
    add(6'b000000, 1, e_immwb,  "ori_wb");
    add(6'b000000, 1, c_FETCH,  "slti_fetch");
    add(6'b001010, 1, c_DECODE, "slti_decode");
    add(6'b000000, 1, mk(4'd10,0,0,0,0,0,0,0,0,0,1,0,2'b10,2'b00,3'b101), "slti_ex");
    add(6'b000000, 1, e_immwb,  "slti_wb");
    // illegal opcode, then beq and j
    add(6'b000000, 1, c_FETCH,  "ill_fetch");
    add(6'b111111, 1, e_ill,    "ill_decode");
    add(6'b000000, 1, c_FETCH,  "ill_next_fetch");
    add(6'b000100, 1, c_DECODE, "beq_decode");
    add(6'b000000, 1, e_branch, "beq_branch");
    add(6'b000000, 1, c_FETCH,  "j_fetch");
    add(6'b000010, 1, c_DECODE, "j_decode");
    add(6'b000000, 1, e_jump,   "j_jump");
    add(6'b000000, 1, c_FETCH,  "j_next_fetch");

    rst = 1'b1; opcode = 6'b100011; mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1 check("reset_state", c_ZERO);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      opcode = vecs[i].op; mem_ready = vecs[i].mr;
      #1 check(vecs[i].name, vecs[i].exp);
      @(negedge clk);
    end

    // Asynchronous reset while MEMRD is waiting for memory
    opcode = 6'b100011; mem_ready = 1'b1;
    #1 check("ar_decode", c_DECODE);
    @(negedge clk);
    #1 check("ar_memadr", e_memadr);
    @(negedge clk);
    mem_ready = 1'b0;
    #1 check("ar_memrd", e_memrd);
    @(negedge clk);
    #1 check("ar_memrd_hold", e_memrd);
    #1 rst = 1'b1;
    #1 check("ar_async_clear", c_ZERO);
    @(negedge clk);
    mem_ready = 1'b1;
    #1 check("ar_held_in_reset", c_ZERO);
    rst = 1'b0;
    #1 check("ar_released_idle", c_ZERO);
    @(posedge clk);
    #1 check("ar_fetch_after", c_FETCH);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, limit 100000 ns reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/main_control_fsm.md
MAIN_CONTROL_FSM -- requirements
Module: main_control_fsm

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have opcode  in  6  instruction[31:26] from the instruction register.
REQ-004 SHALL have mem_ready  in  1  memory access completes this cycle.
REQ-005 SHALL have the following 1-bit outputs: pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op.
REQ-006 SHALL have alu_src_b  out  2  00=regB, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
REQ-007 SHALL have pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target.
REQ-008 SHALL have alu_op  out  3  ALU-control request: 000 add, 001 sub, 010 R-type/funct, 011 and, 100 or, 101 slt.
REQ-009 SHALL have state  out  4  current state code, for debug.

Function
REQ-010 SHALL be a multicycle Moore FSM; all outputs decode from state, except those qualified by mem_ready as stated.
REQ-011 SHALL use state codes: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, RTEX=7, RTWB=8, BRANCH=9, IMMEX=10, IMMWB=11, JUMP=12.
REQ-012 SHALL treat any output not listed for a state as 0; codes 13-15 SHALL behave as IDLE.
REQ-013 IDLE SHALL drive all outputs 0 and go to FETCH next cycle.
REQ-014 FETCH SHALL drive mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=000, pc_source=00.
REQ-015 In FETCH, ir_write and pc_write SHALL equal mem_ready; the FSM SHALL hold FETCH while mem_ready=0 and go to DECODE when mem_ready=1.
REQ-016 DECODE SHALL drive alu_src_a=0, alu_src_b=11, alu_op=000 and register opcode into an internal op_q.
REQ-017 DECODE SHALL go to MEMADR for lw (100011) or sw (101011).
REQ-018 DECODE SHALL go to RTEX for 000000, BRANCH for beq (000100), JUMP for j (000010), and IMMEX for addi (001000), andi (001100), ori (001101) and slti (001010).
REQ-019 For any other opcode, DECODE SHALL assert illegal_op for that cycle only and go to FETCH.
REQ-020 MEMADR SHALL drive alu_src_a=1, alu_src_b=10, alu_op=000, then go to MEMRD if op_q=lw, else MEMWR.
REQ-021 MEMRD SHALL drive mem_read=1 and i_or_d=1; it SHALL hold until mem_ready=1, then go to MEMWB.
REQ-022 MEMWB SHALL drive reg_write=1, mem_to_reg=1, reg_dst=0, then go to FETCH.
REQ-023 MEMWR SHALL drive mem_write=1 and i_or_d=1; it SHALL hold until mem_ready=1, then go to FETCH.
REQ-024 RTEX SHALL drive alu_src_a=1, alu_src_b=00, alu_op=010, then go to RTWB.
REQ-025 RTWB SHALL drive reg_write=1, reg_dst=1, mem_to_reg=0, then go to FETCH.
REQ-026 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_op=001, pc_write_cond=1, pc_source=01, then go to FETCH.
REQ-027 IMMEX SHALL drive alu_src_a=1, alu_src_b=10, then go to IMMWB.
REQ-028 In IMMEX, alu_op SHALL be 000 for addi, 011 for andi, 100 for ori and 101 for slti, selected from op_q.
REQ-029 IMMWB SHALL drive reg_write=1, reg_dst=0, mem_to_reg=0, then go to FETCH.
REQ-030 JUMP SHALL drive pc_write=1 and pc_source=10, then go to FETCH.
REQ-031 SHALL decode opcode only in DECODE; opcode changes in other states SHALL have no effect.
REQ-032 pc_write and pc_write_cond SHALL never both be 1; mem_read and mem_write SHALL never both be 1.

Reset
REQ-033 rst=1 SHALL force state=IDLE and op_q=000000 immediately, without waiting for a clock edge; every output SHALL then be 0, including state=0.
REQ-034 rst asserted mid-instruction SHALL abandon the instruction: no reg_write or mem_write once rst rises, and an in-progress memory wait SHALL be discarded.
REQ-035 After rst falls, the first rising edge SHALL move IDLE->FETCH.

Verification
REQ-036 Reset, then lw with mem_ready=1 every cycle -> states 1,2,3,4,5,1; reg_write=1 only in MEMWB; 5 cycles per instruction.
REQ-037 sw with mem_ready=0 for 3 cycles in MEMWR -> state holds 6 for 4 cycles with mem_write=1, then returns to 1.
REQ-038 addi, andi, ori, slti in turn -> alu_op in IMMEX equals 000, 011, 100, 101; IMMWB has reg_write=1, reg_dst=0.
REQ-039 Opcode 111111 in DECODE -> illegal_op=1 for exactly one cycle; next state 1; no reg_write or mem_write.
REQ-040 beq and j -> BRANCH drives pc_write_cond=1, pc_source=01, alu_op=001; JUMP drives pc_write=1, pc_source=10.
REQ-041 rst pulsed asynchronously while in MEMRD (mem_ready=0) -> state=0 and all outputs 0 within that cycle; after release, FETCH follows on the next edge.
